// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes and
// datapath select codes, plus the DECODE dispatch function.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_TRAP      = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_IMM = 2'b11;
    localparam logic [1:0] PC_ALU  = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;
    localparam logic [1:0] DST_RT  = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;

    function automatic state_e decode_op(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE:        return (fn == FN_JR) ? S_JR : S_R_EXEC;
            OP_LW, OP_SW:    return S_MEM_ADDR;
            OP_BEQ, OP_BNE:  return S_BRANCH;
            OP_J:            return S_JUMP;
            OP_JAL:          return S_JAL;
            OP_ADDI, OP_SLTI: return S_I_EXEC;
            default:         return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified-memory handshake between the control FSM and the memory port.
interface multicycle_ctrl_if;
    logic mem_req_o;
    logic mem_read_o;
    logic mem_write_o;
    logic iord_o;
    logic mem_ready_i;

    modport master (output mem_req_o, mem_read_o, mem_write_o, iord_o, input mem_ready_i);
    modport slave  (input mem_req_o, mem_read_o, mem_write_o, iord_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_ctrl_timer.sv
// Memory wait watchdog: counts stalled cycles, flags the cycle in which the
// stall budget is used up so the FSM can trap instead of waiting again.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) cnt_q <= '0;
        else if (en_i)       cnt_q <= cnt_q + TW'(1);
    end

    assign expired_o = en_i && (cnt_q == LIMIT);
endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS core: sequences fetch/decode/execute,
// decodes datapath selects from the state register, traps on bad opcode/timeout.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    multicycle_ctrl_if.master mem,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [3:0]       state_o,
    output logic             trap_o,
    output logic [CNT_W-1:0] instr_count_o
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               trap_q;
    logic               retire, in_wait, expired;
    logic               ready;

    assign ready = mem.mem_ready_i;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!(in_wait && !ready)),
        .en_i      (in_wait && !ready),
        .expired_o (expired)
    );

    // A ready in the limit cycle is checked first, so completion beats timeout.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        in_wait = 1'b0;
        case (state_q)
            S_FETCH: begin
                in_wait = 1'b1;
                if (ready)        state_d = S_DECODE;
                else if (expired) state_d = S_TRAP;
            end
            S_DECODE:   state_d = decode_op(opcode_i, funct_i);
            S_MEM_ADDR: state_d = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                in_wait = 1'b1;
                if (ready)        state_d = S_MEM_WB;
                else if (expired) state_d = S_TRAP;
            end
            S_MEM_WRITE: begin
                in_wait = 1'b1;
                if (ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (expired) state_d = S_TRAP;
            end
            S_R_EXEC: state_d = S_R_WB;
            S_I_EXEC: state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
            if (state_d == S_TRAP) trap_q <= 1'b1;
        end
    end

    logic req, rd, wr, irw, pcw, rgw;

    always_comb begin
        req = 1'b0; rd = 1'b0; wr = 1'b0; irw = 1'b0; pcw = 1'b0; rgw = 1'b0;
        mem.iord_o   = 1'b0;
        pc_src_o     = PC_ALU;
        reg_dst_o    = DST_RT;
        mem_to_reg_o = M2R_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        alu_op_o     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                req = 1'b1; rd = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                irw = ready; pcw = ready;
            end
            S_DECODE:    alu_src_b_o = SRCB_IMM_SH;
            S_MEM_ADDR:  begin alu_src_a_o = 1'b1; alu_src_b_o = SRCB_IMM; end
            S_MEM_READ:  begin req = 1'b1; rd = 1'b1; mem.iord_o = 1'b1; end
            S_MEM_WRITE: begin req = 1'b1; wr = 1'b1; mem.iord_o = 1'b1; end
            S_MEM_WB:    begin rgw = 1'b1; mem_to_reg_o = M2R_MDR; end
            S_R_EXEC:    begin alu_src_a_o = 1'b1; alu_op_o = ALU_FUNCT; end
            S_R_WB:      begin rgw = 1'b1; reg_dst_o = DST_RD; end
            S_I_EXEC:    begin alu_src_a_o = 1'b1; alu_src_b_o = SRCB_IMM; alu_op_o = ALU_IMM; end
            S_I_WB:      rgw = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = 1'b1; alu_op_o = ALU_SUB; pc_src_o = PC_ALUOUT;
                pcw = (opcode_i == OP_BNE) ? !zero_i : zero_i;
            end
            S_JUMP:      begin pcw = 1'b1; pc_src_o = PC_JUMP; end
            S_JAL: begin
                pcw = 1'b1; pc_src_o = PC_JUMP;
                rgw = 1'b1; reg_dst_o = DST_RA; mem_to_reg_o = M2R_PC;
            end
            S_JR:        begin pcw = 1'b1; pc_src_o = PC_RS; end
            default: ;
        endcase
    end

    // Strobes are held low for the whole reset cycle, even mid-access.
    assign mem.mem_req_o   = rst_i & req;
    assign mem.mem_read_o  = rst_i & rd;
    assign mem.mem_write_o = rst_i & wr;
    assign ir_write_o      = rst_i & irw;
    assign pc_write_o      = rst_i & pcw;
    assign reg_write_o     = rst_i & rgw;

    assign state_o       = state_q;
    assign trap_o        = trap_q;
    assign instr_count_o = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequencing, memory waits,
// branch conditions, reset mid-access, timeout and illegal-opcode traps.
module tb_multicycle_ctrl;
    logic        clk;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        ir_write, pc_write, reg_write, alu_src_a, trap;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [15:0] count;
    int          checks = 0;
    int          errors = 0;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
        .mem(mif.master),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
        .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .state_o(state), .trap_o(trap), .instr_count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mif.mem_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_state", 32'(state), 0);
        chk("init_req", 32'(mif.mem_req_o), 0);
        chk("init_count", 32'(count), 0);
        chk("init_trap", 32'(trap), 0);

        // add: 0,1,6,7,0
        @(negedge clk); rst = 1'b1; opcode = 6'h00; funct = 6'h20; mif.mem_ready_i = 1'b1; #1;
        chk("add_fetch_state", 32'(state), 0);
        chk("add_fetch_irw", 32'(ir_write), 1);
        chk("add_fetch_pcw", 32'(pc_write), 1);
        chk("add_fetch_rd", 32'(mif.mem_read_o), 1);
        chk("add_fetch_srcb", 32'(alu_src_b), 1);
        @(negedge clk); #1;
        chk("add_decode", 32'(state), 1);
        chk("add_decode_srcb", 32'(alu_src_b), 3);
        @(negedge clk); #1;
        chk("add_rexec", 32'(state), 6);
        chk("add_rexec_op", 32'(alu_op), 2);
        @(negedge clk); #1;
        chk("add_rwb", 32'(state), 7);
        chk("add_rwb_rw", 32'(reg_write), 1);
        chk("add_rwb_dst", 32'(reg_dst), 1);
        chk("add_rwb_m2r", 32'(mem_to_reg), 0);
        @(negedge clk); opcode = 6'h23; #1;
        chk("add_done", 32'(state), 0);
        chk("add_count", 32'(count), 1);

        // lw with three wait cycles in MEM_READ: 8 cycles total
        @(negedge clk); #1;
        chk("lw_decode", 32'(state), 1);
        chk("lw_decode_rw", 32'(reg_write), 0);
        @(negedge clk); mif.mem_ready_i = 1'b0; #1;
        chk("lw_addr", 32'(state), 2);
        chk("lw_addr_a", 32'(alu_src_a), 1);
        chk("lw_addr_b", 32'(alu_src_b), 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("lw_wait_state", 32'(state), 3);
            chk("lw_wait_rd", 32'(mif.mem_read_o), 1);
            chk("lw_wait_iord", 32'(mif.iord_o), 1);
            chk("lw_wait_rw", 32'(reg_write), 0);
        end
        @(negedge clk); mif.mem_ready_i = 1'b1; #1;
        chk("lw_ready_state", 32'(state), 3);
        @(negedge clk); #1;
        chk("lw_wb", 32'(state), 4);
        chk("lw_wb_rw", 32'(reg_write), 1);
        chk("lw_wb_m2r", 32'(mem_to_reg), 1);
        chk("lw_wb_dst", 32'(reg_dst), 0);
        @(negedge clk); opcode = 6'h2B; #1;
        chk("lw_done", 32'(state), 0);
        chk("lw_count", 32'(count), 2);

        // sw with two wait cycles
        @(negedge clk); #1;
        chk("sw_decode", 32'(state), 1);
        @(negedge clk); mif.mem_ready_i = 1'b0; #1;
        chk("sw_addr", 32'(state), 2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("sw_wait_state", 32'(state), 5);
            chk("sw_wait_wr", 32'(mif.mem_write_o), 1);
            chk("sw_wait_rd", 32'(mif.mem_read_o), 0);
            chk("sw_wait_rw", 32'(reg_write), 0);
        end
        @(negedge clk); mif.mem_ready_i = 1'b1; #1;
        chk("sw_ready_wr", 32'(mif.mem_write_o), 1);
        @(negedge clk); opcode = 6'h04; zero = 1'b1; #1;
        chk("sw_done", 32'(state), 0);
        chk("sw_count", 32'(count), 3);

        // beq taken
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("beq_t_state", 32'(state), 10);
        chk("beq_t_pcw", 32'(pc_write), 1);
        chk("beq_t_src", 32'(pc_src), 1);
        chk("beq_t_op", 32'(alu_op), 1);
        @(negedge clk); zero = 1'b0; #1;
        chk("beq_t_count", 32'(count), 4);

        // beq not taken
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("beq_n_state", 32'(state), 10);
        chk("beq_n_pcw", 32'(pc_write), 0);
        @(negedge clk); opcode = 6'h05; #1;

        // bne: both zero values in the BRANCH cycle
        @(negedge clk); #1;
        @(negedge clk); zero = 1'b1; #1;
        chk("bne_state", 32'(state), 10);
        chk("bne_z1_pcw", 32'(pc_write), 0);
        zero = 1'b0; #1;
        chk("bne_z0_pcw", 32'(pc_write), 1);
        @(negedge clk); opcode = 6'h03; #1;
        chk("bne_count", 32'(count), 6);

        // jal
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("jal_state", 32'(state), 12);
        chk("jal_rw", 32'(reg_write), 1);
        chk("jal_dst", 32'(reg_dst), 2);
        chk("jal_m2r", 32'(mem_to_reg), 2);
        chk("jal_src", 32'(pc_src), 2);
        chk("jal_pcw", 32'(pc_write), 1);
        @(negedge clk); opcode = 6'h00; funct = 6'h08; #1;

        // jr
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("jr_state", 32'(state), 13);
        chk("jr_src", 32'(pc_src), 3);
        chk("jr_rw", 32'(reg_write), 0);
        chk("jr_pcw", 32'(pc_write), 1);
        @(negedge clk); opcode = 6'h23; #1;
        chk("jr_count", 32'(count), 8);

        // reset in the middle of a MEM_READ wait
        @(negedge clk); #1;
        @(negedge clk); mif.mem_ready_i = 1'b0; #1;
        @(negedge clk); #1;
        chk("rst_mid_pre", 32'(state), 3);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_mid_req", 32'(mif.mem_req_o), 0);
        chk("rst_mid_rd", 32'(mif.mem_read_o), 0);
        @(negedge clk); #1;
        chk("rst_mid_state", 32'(state), 0);
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_trap", 32'(trap), 0);
        chk("rst_mid_irw", 32'(ir_write), 0);

        // ready in the last allowed FETCH cycle completes normally
        @(negedge clk); rst = 1'b1; #1;
        for (int i = 1; i < 15; i++) @(negedge clk);
        @(negedge clk); mif.mem_ready_i = 1'b1; #1;
        chk("limit_fetch_state", 32'(state), 0);
        chk("limit_irw", 32'(ir_write), 1);
        @(negedge clk); #1;
        chk("limit_decode", 32'(state), 1);
        chk("limit_trap", 32'(trap), 0);

        // fetch timeout: 16 stalled cycles then TRAP
        @(negedge clk); rst = 1'b0; mif.mem_ready_i = 1'b0; #1;
        @(negedge clk); rst = 1'b1; #1;
        for (int i = 1; i < 16; i++) @(negedge clk);
        #1;
        chk("to_last_fetch", 32'(state), 0);
        @(negedge clk); #1;
        chk("to_state", 32'(state), 14);
        chk("to_trap", 32'(trap), 1);
        chk("to_req", 32'(mif.mem_req_o), 0);
        @(negedge clk); mif.mem_ready_i = 1'b1; #1;
        @(negedge clk); #1;
        chk("to_hold_state", 32'(state), 14);
        chk("to_hold_trap", 32'(trap), 1);

        // illegal opcode traps after DECODE
        @(negedge clk); rst = 1'b0; opcode = 6'h3F; #1;
        @(negedge clk); rst = 1'b1; #1;
        chk("ill_fetch", 32'(state), 0);
        @(negedge clk); #1;
        chk("ill_decode", 32'(state), 1);
        @(negedge clk); #1;
        chk("ill_state", 32'(state), 14);
        chk("ill_trap", 32'(trap), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("ill_hold", 32'(state), 14);
        chk("ill_count", 32'(count), 0);
        chk("ill_pcw", 32'(pc_write), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
